// File: rtl/alu_serial_driver.sv
// Bit-serial ALU: one bit per clock through a 1-bit slice with carry feedback, LSB first.
// Optional zero/ovf flag outputs are enabled with `define ALU_SERIAL_FLAGS_EN.
module alu_serial_driver #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [1:0]         sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
`ifdef ALU_SERIAL_FLAGS_EN
    logic               zacc_q, zacc_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
`endif

    logic slice_a, slice_b, slice_c, slice_bit, slice_co, is_arith;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sh_q        <= '0;
            res_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            zacc_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sh_q        <= sh_d;
            res_q       <= res_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_SERIAL_FLAGS_EN
            zacc_q      <= zacc_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    // 1-bit ALU slice; B is inverted per bit for SUB with carry seeded to 1
    always_comb begin
        is_arith  = ~sel_q[1];
        slice_a   = a_q[0];
        slice_b   = b_q[0] ^ (sel_q == 2'b01);
        slice_c   = carry_q;
        slice_bit = 1'b0;
        slice_co  = 1'b0;
        case (sel_q)
            2'b00, 2'b01: begin
                slice_bit = slice_a ^ slice_b ^ slice_c;
                slice_co  = (slice_a & slice_b) | (slice_c & (slice_a ^ slice_b));
            end
            2'b10:   slice_bit = slice_a & slice_b;
            default: slice_bit = slice_a | slice_b;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sh_d        = sh_q;
        res_d       = res_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef ALU_SERIAL_FLAGS_EN
        zacc_d      = zacc_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = i0;
                    b_d        = i1;
                    sel_d      = sel;
                    cnt_d      = '0;
                    carry_d    = (sel == 2'b01);
                    in_ready_d = 1'b0;
                    state_d    = S_SHIFT;
`ifdef ALU_SERIAL_FLAGS_EN
                    zacc_d     = 1'b1;
`endif
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = {slice_bit, sh_q[WIDTH-1:1]};
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef ALU_SERIAL_FLAGS_EN
                zacc_d  = zacc_q & ~slice_bit;
`endif
                // Last bit: publish the completed result directly from the slice
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_d       = {slice_bit, sh_q[WIDTH-1:1]};
                    cout_d      = slice_co;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
`ifdef ALU_SERIAL_FLAGS_EN
                    zero_d      = zacc_q & ~slice_bit;
                    ovf_d       = is_arith & (slice_c ^ slice_co);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign cout      = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_driver.sv
// Scoreboard bench for alu_serial_driver: driver pushes expected results, a negedge monitor pops on handshake.
module tb_alu_serial_driver;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] i0, i1;
    logic [1:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         cout;
`ifdef ALU_SERIAL_FLAGS_EN
    logic         zero, ovf;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_serial_driver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i0        (i0),
        .i1        (i1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cout      (cout)
`ifdef ALU_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] r, input logic c, input logic z, input logic o);
        exp_t e;
        e.res = r; e.cout = c; e.zero = z; e.ovf = o;
        sb.push_back(e);
    endtask

    // Present a bundle, wait for acceptance, then scramble inputs to prove they were latched
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        int k = 0;
        i0 = a; i1 = b; sel = s; in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 100) chk("accept_timeout", 64'(k), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        i0 = ~a; i1 = ~b; sel = ~s;
    endtask

    // Count edges from acceptance to out_valid and confirm in_ready stays low
    task automatic wait_out(input string name);
        int lat = 0;
        bit ir_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) ir_bad = 1'b1;
        chk({name, "_latency"}, 64'(lat), 64'(W));
        chk({name, "_in_ready_low"}, 64'(ir_bad), 64'(0));
    endtask

    task automatic drop_check(input string name);
        @(posedge clk); #1;
        chk({name, "_out_valid_drop"}, 64'(out_valid), 64'(0));
        chk({name, "_in_ready_back"}, 64'(in_ready), 64'(1));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] s, input logic [W-1:0] r, input logic c,
                          input logic z, input logic o);
        push(r, c, z, o);
        accept(a, b, s);
        wait_out(name);
        drop_check(name);
    endtask

    // Monitor: compare whenever a result is handed over
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 64'(res), 64'(0));
                    if (res == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected_output: got output, expected none");
                    end
                end else begin
                    e = sb.pop_front();
                    chk("res", 64'(res), 64'(e.res));
                    chk("cout", 64'(cout), 64'(e.cout));
`ifdef ALU_SERIAL_FLAGS_EN
                    chk("zero", 64'(zero), 64'(e.zero));
                    chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held_res;
        logic         held_cout;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        i0 = '0; i1 = '0; sel = 2'b00;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_res", 64'(res), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        run_op("add",   16'hff00, 16'h00ab, 2'b00, 16'hffab, 1'b0, 1'b0, 1'b0);
        run_op("sub1",  16'hffa0, 16'h00ff, 2'b01, 16'hfea1, 1'b1, 1'b0, 1'b0);
        run_op("sub2",  16'h0001, 16'h0002, 2'b01, 16'hffff, 1'b0, 1'b0, 1'b0);
        run_op("and",   16'hffa0, 16'h00ff, 2'b10, 16'h00a0, 1'b0, 1'b0, 1'b0);
        run_op("or",    16'hffa0, 16'h00ff, 2'b11, 16'hffff, 1'b0, 1'b0, 1'b0);
        run_op("wrap",  16'hffff, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("sovf",  16'h7fff, 16'h0001, 2'b00, 16'h8000, 1'b0, 1'b0, 1'b1);

        // Backpressure: result held while the consumer stalls, inputs ignored
        out_ready = 1'b0;
        push(16'h0246, 1'b0, 1'b0, 1'b0);
        accept(16'h0123, 16'h0123, 2'b00);
        wait_out("bp");
        held_res  = res;
        held_cout = cout;
        chk("bp_res_value", 64'(held_res), 64'(16'h0246));
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid;
            i0 = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_res_stable", 64'(res), 64'(held_res));
            chk("bp_cout_stable", 64'(cout), 64'(held_cout));
            chk("bp_out_valid_held", 64'(out_valid), 64'(1));
            chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drop_check("bp");

        // Asynchronous reset mid-operation discards the result
        accept(16'h5555, 16'h1111, 2'b00);
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_res", 64'(res), 64'(0));
        chk("arst_cout", 64'(cout), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        chk("arst_no_out", 64'(out_valid), 64'(0));
        run_op("fresh", 16'h1234, 16'h1111, 2'b00, 16'h2345, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
